regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Shares the single write port of the 32 x 64-bit regfile between NREQ writeback requesters (ALU, load unit, multiplier, ...). It uses fair round-robin arbitration with a valid/ready handshake. The grant is registered into a one-stage write buffer that drives the regfile RegWrite/WriteRegister/WriteData pins. Writes to X31 (XZR) are consumed but never reach the regfile; a forwarding copy of the buffered write is exported for bypass.

Parameters:
NREQ, 4, number of writeback requesters (2..8)
REG_W, 64, data width
ADDR_W, 5, register address width

Ports:
clk  in  1  system clock, all state on posedge
reset_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  requester i has a write pending
req_addr  in  NREQ x ADDR_W  destination register per requester
req_data  in  NREQ x REG_W  write data per requester
req_ready  out  NREQ  one-hot grant; handshake when valid & ready at posedge
hold  in  1  freeze: no grants while high
RegWrite  out  1  to regfile write enable
WriteRegister  out  ADDR_W  to regfile write address
WriteData  out  REG_W  to regfile write data
fwd_valid  out  1  buffered write is live (includes X31-dropped = 0)
fwd_addr  out  ADDR_W  copy of WriteRegister
fwd_data  out  REG_W  copy of WriteData
drop_count  out  16  saturating count of accepted X31 writes

Behaviour:
- Reset (reset_n low, async): RegWrite=0, WriteRegister=0, WriteData=0, fwd_valid=0, drop_count=0, rr pointer=0, req_ready=0. An in-flight buffered write is discarded.
- Grant (combinational): if hold=0 and any req_valid, pick the first valid i scanning from pointer upward modulo NREQ. req_ready=onehot(i), otherwise all zero. req_ready may depend on req_valid; requesters must not make valid depend on ready.
- Requester rules: once req_valid is raised, valid/addr/data stay stable until the handshake.
- Pointer: on handshake with i, pointer <= (i+1) mod NREQ. With no handshake, pointer holds. Worst-case wait is NREQ-1 grants.
- Latency: handshake at posedge k. Buffer outputs are valid in cycle k..k+1. The regfile captures at posedge k+1. Throughput is one write per cycle.
- Buffer load at each posedge:
  - Handshake with addr != 31: RegWrite<=1, WriteRegister<=addr, WriteData<=data, fwd_valid<=1.
  - Handshake with addr == 31: RegWrite<=0, fwd_valid<=0, drop_count<=drop_count+1, saturating at 16'hFFFF. WriteRegister/WriteData still load, for debug only.
  - No handshake, including hold=1: RegWrite<=0, fwd_valid<=0. WriteRegister/WriteData hold their values.
- Back-to-back writes to the same register from different requesters are serialized in grant order, so the last grant wins in the regfile.
- hold asserted mid-stream: the already buffered write still retires next edge. No new grants while hold=1. The pointer is unchanged.
- NREQ=1 degenerates to pass-through with one cycle latency.

Decomposition:
- Shared package regfile_pkg: NUM_REGS=32, REG_W=64, ADDR_W=5, XZR_ADDR=5'd31, typedef reg_addr_t (logic [4:0]), typedef reg_data_t (logic [63:0]).
- Sub-module rr_arbiter #(N): inputs req and pointer, output one-hot grant. Purely combinational, with a double-width masked priority scan.
- The top holds the pointer, write buffer and drop counter.

Test Plan:
1. Reset mid-write: requester 0 writes X5=64'hA0, and reset_n is pulsed low one cycle later -> RegWrite=0 immediately (async). The regfile keeps its old X5. drop_count=0.
2. Round-robin fairness: all 4 valid continuously with distinct addrs 1,2,3,4 -> grants go 0,1,2,3 on consecutive cycles. RegWrite stays high 4 cycles with WriteRegister 1,2,3,4. The pointer returns to 0.
3. Pointer wrap: pointer=3 after granting 2; requesters 0 and 3 valid -> 3 granted first, then 0. Pointer ends at 1.
4. XZR drop: requester 1 writes X31=64'h00000000000000A0 -> req_ready[1]=1, RegWrite stays 0, fwd_valid=0, drop_count=1. A regfile read of X31 returns 0.
5. Hold: all valid with hold=1 for 3 cycles -> req_ready=0 and RegWrite=0 after the buffered write drains. The pointer is unchanged. Grants resume on the first cycle after hold=0.
6. Full pattern: write i*64'h0000010204080001 to X0..X30 via alternating requesters -> every register reads back its pattern, and X31 reads 0. drop_count saturates at 16'hFFFF after 65536+ X31 writes.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared constants and types for the integer register file and its
//   writeback path: register count, data/address widths, the index of the
//   hard-wired zero register (XZR) and convenience typedefs.
//   No ports (package only).
package regfile_pkg;

  localparam int         NUM_REGS = 32;
  localparam int         REG_W    = 64;
  localparam int         ADDR_W   = 5;
  localparam logic [4:0] XZR_ADDR = 5'd31;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_W-1:0]  reg_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin arbiter. Picks the first asserted request at
//   or above 'pointer', wrapping around modulo N.
//   Ports:
//     req     in  N      request vector
//     pointer in  PTR_W  index with highest priority this cycle
//     grant   out N      one-hot grant (all zero when no request)
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] pointer,
  output logic [N-1:0]     grant
);

  logic [2*N-1:0] doubled;
  logic           found;

  // The request vector is duplicated and the low copy is masked below the
  // pointer, so a single upward scan of the doubled vector finds the first
  // request at or above the pointer and then wraps into the upper copy.
  always_comb begin
    doubled = {req, req};
    grant   = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (k < int'(pointer)) begin
        doubled[k] = 1'b0;
      end
    end
    for (int k = 0; k < 2*N; k++) begin
      if (!found && doubled[k]) begin
        found        = 1'b1;
        grant[k % N] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single regfile write port between NREQ writeback requesters
//   with round-robin arbitration and a valid/ready handshake. The winner is
//   registered into a one-entry write buffer that drives the regfile write
//   pins; writes to X31 (XZR) are accepted but never reach the regfile.
//   Ports:
//     clk, reset_n          clock, asynchronous active-low reset
//     req_valid/addr/data   per-requester write request (flattened arrays)
//     req_ready             one-hot grant, handshake on valid & ready
//     hold                  blocks all new grants while high
//     RegWrite, WriteRegister, WriteData   regfile write port
//     fwd_valid/addr/data   copy of the buffered write for bypassing
//     drop_count            saturating count of accepted X31 writes
module regfile_wb_arbiter #(
  parameter int NREQ   = 4,
  parameter int REG_W  = 64,
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*REG_W-1:0]  req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   hold,
  output logic                   RegWrite,
  output logic [ADDR_W-1:0]      WriteRegister,
  output logic [REG_W-1:0]       WriteData,
  output logic                   fwd_valid,
  output logic [ADDR_W-1:0]      fwd_addr,
  output logic [REG_W-1:0]       fwd_data,
  output logic [15:0]            drop_count
);

  import regfile_pkg::XZR_ADDR;

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0]  pointer;
  logic [PTR_W-1:0]  nextPointer;
  logic [NREQ-1:0]   grant;
  logic              handshake;
  logic [ADDR_W-1:0] selAddr;
  logic [REG_W-1:0]  selData;
  logic              selIsZeroReg;

  rr_arbiter #(.N(NREQ), .PTR_W(PTR_W)) arb (
    .req     (req_valid),
    .pointer (pointer),
    .grant   (grant)
  );

  // The arbiter only grants valid requesters, so any ready bit is a handshake.
  assign req_ready    = hold ? '0 : grant;
  assign handshake    = |(req_ready & req_valid);
  assign selIsZeroReg = (selAddr == ADDR_W'(XZR_ADDR));

  // Mux out the winner's address/data and the pointer slot just after it.
  always_comb begin
    selAddr     = '0;
    selData     = '0;
    nextPointer = pointer;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        selAddr     = req_addr[i*ADDR_W +: ADDR_W];
        selData     = req_data[i*REG_W +: REG_W];
        nextPointer = (i == NREQ-1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  // Pointer and write buffer. Address/data load on every handshake (even
  // for X31, as a debug aid) but only the enable distinguishes a real write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pointer       <= '0;
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else begin
      pointer  <= nextPointer;
      RegWrite <= handshake && !selIsZeroReg;
      if (handshake) begin
        WriteRegister <= selAddr;
        WriteData     <= selData;
      end
    end
  end

  // Count of writes swallowed by XZR, sticking at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= '0;
    end else if (handshake && selIsZeroReg && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end

  assign fwd_valid = RegWrite;
  assign fwd_addr  = WriteRegister;
  assign fwd_data  = WriteData;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//   Self-checking bench for regfile_wb_arbiter (NREQ=4): async reset during
//   a buffered write, a table of hand-derived vectors (fairness, wrap, XZR
//   drop, hold), randomized traffic against a behavioural model, a full
//   register pattern read back through a bench-side regfile, and drop
//   counter saturation.
module tb_regfile_wb_arbiter;

  localparam int          NREQ    = 4;
  localparam logic [63:0] PATTERN = 64'h0000010204080001;
  localparam logic [19:0] ADDRS_A = {5'd4, 5'd3, 5'd2, 5'd1};
  localparam logic [19:0] ADDRS_B = {5'd4, 5'd7, 5'd2, 5'd1};
  localparam logic [19:0] ADDRS_C = {5'd9, 5'd7, 5'd2, 5'd8};
  localparam logic [19:0] ADDRS_D = {5'd9, 5'd7, 5'd31, 5'd8};

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [19:0]  req_addr;
  logic [255:0] req_data;
  logic [3:0]   req_ready;
  logic         hold = 1'b0;
  logic         RegWrite;
  logic [4:0]   WriteRegister;
  logic [63:0]  WriteData;
  logic         fwd_valid;
  logic [4:0]   fwd_addr;
  logic [63:0]  fwd_data;
  logic [15:0]  drop_count;

  logic [4:0]   vAddr [4];
  logic [63:0]  vData [4];
  logic [63:0]  mem [32];
  logic         memClear = 1'b1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  valid;
    logic        hold;
    logic [19:0] addrs;
    logic [3:0]  expReady;
    logic        expWrite;
    logic [4:0]  expReg;
    logic [63:0] expData;
    logic [15:0] expDrops;
  } vector_t;

  vector_t vec [14];

  regfile_wb_arbiter #(.NREQ(4), .REG_W(64), .ADDR_W(5)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .hold          (hold),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .fwd_valid     (fwd_valid),
    .fwd_addr      (fwd_addr),
    .fwd_data      (fwd_data),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  // Pack the per-requester address/data arrays into the flat DUT ports.
  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*5 +: 5]   = vAddr[i];
      req_data[i*64 +: 64] = vData[i];
    end
  end

  // Bench-side regfile: captures the write port on each rising edge.
  always @(posedge clk) begin
    if (memClear) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (RegWrite) begin
      mem[WriteRegister] <= WriteData;
    end
  end

  // Hard stop in case anything wedges.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [3:0] v, input logic h, input logic [19:0] a);
    req_valid = v;
    hold      = h;
    for (int i = 0; i < NREQ; i++) vAddr[i] = a[i*5 +: 5];
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model state for the random phase.
  int          mPtr;
  int          mDrops;
  logic        eWrite;
  logic [4:0]  eReg;
  logic [63:0] eData;
  logic        pend [4];
  logic [4:0]  pA [4];
  logic [63:0] pD [4];
  logic [63:0] expMem [32];
  logic        written [32];

  initial begin
    // Table of hand-derived vectors, applied from a freshly reset DUT.
    vec[0]  = '{4'b1111, 1'b0, ADDRS_A, 4'b0001, 1'b1, 5'd1,  64'h100, 16'd0};
    vec[1]  = '{4'b1111, 1'b0, ADDRS_A, 4'b0010, 1'b1, 5'd2,  64'h101, 16'd0};
    vec[2]  = '{4'b1111, 1'b0, ADDRS_A, 4'b0100, 1'b1, 5'd3,  64'h102, 16'd0};
    vec[3]  = '{4'b1111, 1'b0, ADDRS_A, 4'b1000, 1'b1, 5'd4,  64'h103, 16'd0};
    vec[4]  = '{4'b0000, 1'b0, ADDRS_A, 4'b0000, 1'b0, 5'd4,  64'h103, 16'd0};
    vec[5]  = '{4'b0100, 1'b0, ADDRS_B, 4'b0100, 1'b1, 5'd7,  64'h102, 16'd0};
    vec[6]  = '{4'b1001, 1'b0, ADDRS_C, 4'b1000, 1'b1, 5'd9,  64'h103, 16'd0};
    vec[7]  = '{4'b0001, 1'b0, ADDRS_C, 4'b0001, 1'b1, 5'd8,  64'h100, 16'd0};
    vec[8]  = '{4'b0010, 1'b0, ADDRS_D, 4'b0010, 1'b0, 5'd31, 64'h101, 16'd1};
    vec[9]  = '{4'b1111, 1'b0, ADDRS_A, 4'b0100, 1'b1, 5'd3,  64'h102, 16'd1};
    vec[10] = '{4'b1111, 1'b1, ADDRS_A, 4'b0000, 1'b0, 5'd3,  64'h102, 16'd1};
    vec[11] = '{4'b1111, 1'b1, ADDRS_A, 4'b0000, 1'b0, 5'd3,  64'h102, 16'd1};
    vec[12] = '{4'b1111, 1'b1, ADDRS_A, 4'b0000, 1'b0, 5'd3,  64'h102, 16'd1};
    vec[13] = '{4'b1111, 1'b0, ADDRS_A, 4'b1000, 1'b1, 5'd4,  64'h103, 16'd1};

    for (int i = 0; i < NREQ; i++) begin
      vAddr[i] = '0;
      vData[i] = '0;
    end

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    memClear = 1'b0;
    reset_n  = 1'b1;
    #1;
    checkOutput("reset RegWrite", RegWrite, 0);
    checkOutput("reset WriteRegister", WriteRegister, 0);
    checkOutput("reset WriteData", WriteData, 0);
    checkOutput("reset fwd_valid", fwd_valid, 0);
    checkOutput("reset drop_count", drop_count, 0);
    checkOutput("reset req_ready", req_ready, 0);

    // Reset arriving while a write sits in the buffer discards it.
    @(posedge clk); #1;
    vData[0] = 64'hA0;
    applyStimulus(4'b0001, 1'b0, {15'd0, 5'd5});
    #1 checkOutput("rstmid ready", req_ready, 4'b0001);
    @(posedge clk); #1;
    checkOutput("rstmid RegWrite before", RegWrite, 1);
    checkOutput("rstmid WriteRegister before", WriteRegister, 5);
    req_valid = '0;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rstmid RegWrite async", RegWrite, 0);
    checkOutput("rstmid fwd_valid async", fwd_valid, 0);
    checkOutput("rstmid drop_count", drop_count, 0);
    @(posedge clk); #1;
    checkOutput("rstmid X5 untouched", mem[5], 0);
    reset_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < NREQ; i++) vData[i] = 64'h100 + 64'(i);
    for (int r = 0; r < 14; r++) begin
      applyStimulus(vec[r].valid, vec[r].hold, vec[r].addrs);
      #1 checkOutput($sformatf("row%0d req_ready", r), req_ready, vec[r].expReady);
      @(posedge clk); #1;
      checkOutput($sformatf("row%0d RegWrite", r), RegWrite, vec[r].expWrite);
      checkOutput($sformatf("row%0d WriteRegister", r), WriteRegister, vec[r].expReg);
      checkOutput($sformatf("row%0d WriteData", r), WriteData, vec[r].expData);
      checkOutput($sformatf("row%0d fwd_valid", r), fwd_valid, vec[r].expWrite);
      checkOutput($sformatf("row%0d fwd_addr", r), fwd_addr, vec[r].expReg);
      checkOutput($sformatf("row%0d fwd_data", r), fwd_data, vec[r].expData);
      checkOutput($sformatf("row%0d drop_count", r), drop_count, vec[r].expDrops);
    end

    // Randomized traffic against the behavioural model.
    applyStimulus(4'b0000, 1'b0, '0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    mPtr   = 0;
    mDrops = 0;
    eWrite = 1'b0;
    eReg   = '0;
    eData  = '0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0;
      pA[i]   = '0;
      pD[i]   = '0;
    end
    for (int i = 0; i < 32; i++) begin
      written[i] = 1'b0;
      expMem[i]  = '0;
    end
    for (int cyc = 0; cyc < 300; cyc++) begin
      int          g;
      logic [3:0]  expReady;
      logic [3:0]  snap;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1'b1;
          pA[i]   = 5'($urandom_range(0, 31));
          pD[i]   = {$urandom, $urandom};
        end
        vAddr[i]     = pA[i];
        vData[i]     = pD[i];
        req_valid[i] = pend[i];
      end
      hold = ($urandom_range(0, 7) == 0);
      #1;
      g = -1;
      if (!hold) begin
        for (int k = 0; k < NREQ; k++) begin
          if (g < 0 && pend[(mPtr + k) % NREQ]) g = (mPtr + k) % NREQ;
        end
      end
      expReady = (g >= 0) ? 4'(1 << g) : 4'b0000;
      checkOutput("rand req_ready", req_ready, expReady);
      snap = req_ready;
      @(posedge clk); #1;
      if (g >= 0) begin
        mPtr  = (g + 1) % NREQ;
        eReg  = pA[g];
        eData = pD[g];
        if (pA[g] == 5'd31) begin
          eWrite = 1'b0;
          if (mDrops < 65535) mDrops++;
        end else begin
          eWrite          = 1'b1;
          expMem[pA[g]]   = pD[g];
          written[pA[g]]  = 1'b1;
        end
      end else begin
        eWrite = 1'b0;
      end
      checkOutput("rand RegWrite", RegWrite, eWrite);
      checkOutput("rand WriteRegister", WriteRegister, eReg);
      checkOutput("rand WriteData", WriteData, eData);
      checkOutput("rand fwd_valid", fwd_valid, eWrite);
      checkOutput("rand drop_count", drop_count, 64'(mDrops));
      for (int i = 0; i < NREQ; i++) if (snap[i]) pend[i] = 1'b0;
    end
    applyStimulus(4'b0000, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    for (int a = 0; a < 31; a++) begin
      if (written[a]) checkOutput($sformatf("rand regfile X%0d", a), mem[a], expMem[a]);
    end

    // Full register pattern through alternating requesters.
    for (int r = 0; r < 31; r++) begin
      int   who;
      logic got;
      who = r % NREQ;
      vAddr[who] = 5'(r);
      vData[who] = 64'(r) * PATTERN;
      req_valid  = 4'(1 << who);
      got = 1'b0;
      for (int t = 0; t < 8 && !got; t++) begin
        #1;
        if (req_ready[who]) got = 1'b1;
        @(posedge clk); #1;
      end
      req_valid = '0;
      if (!got) checkOutput($sformatf("pattern grant X%0d", r), 0, 1);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int r = 0; r < 31; r++) begin
      checkOutput($sformatf("pattern X%0d", r), mem[r], 64'(r) * PATTERN);
    end
    checkOutput("pattern X31 never written", mem[31], 0);

    // Continuous X31 stream until the drop counter saturates.
    applyStimulus(4'b1111, 1'b0, {5'd31, 5'd31, 5'd31, 5'd31});
    repeat (1000) @(posedge clk);
    #1;
    checkOutput("sat drop_count 1000", drop_count, 64'(mDrops + 1000));
    checkOutput("sat RegWrite low", RegWrite, 0);
    repeat (65000) @(posedge clk);
    #1;
    checkOutput("sat drop_count", drop_count, 16'hFFFF);
    checkOutput("sat fwd_valid low", fwd_valid, 0);
    applyStimulus(4'b0000, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
